tft_vram_fill_engine: RTL and testbench

- Write-side controller for the dual-port video RAM, in the `cclk` domain.
- Merges single-pixel touch writes with a rectangle-fill engine. Full-screen clear is the degenerate rectangle.
- Drives the VRAM write port (enable/address/data) directly.
- Parametrised in resolution, colour depth and address width. It supersedes hand-written clear FSMs and adds arbitrary rectangle fill, coordinate clamping and a busy/done handshake.

---
 rtl/tft_vram_fill_engine_if.sv | 39 +++
 rtl/tft_vram_fill_engine.sv | 173 +++++++++++++++++
 tb/tb_tft_vram_fill_engine.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tft_vram_fill_engine_if.sv
// Request/status/VRAM-write bundle for tft_vram_fill_engine.
// The master drives pixel and fill requests; the slave (engine) drives status and the VRAM write port.
interface tft_vram_fill_engine_if #(
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9,
  parameter int PIXEL_BITS = 9,
  parameter int ADDR_BITS  = 17
);
  logic                  pix_wr_ena;
  logic [X_BITS-1:0]     pix_x;
  logic [Y_BITS-1:0]     pix_y;
  logic [PIXEL_BITS-1:0] pix_data;
  logic                  fill_start;
  logic [X_BITS-1:0]     fill_x0;
  logic [X_BITS-1:0]     fill_x1;
  logic [Y_BITS-1:0]     fill_y0;
  logic [Y_BITS-1:0]     fill_y1;
  logic [PIXEL_BITS-1:0] fill_color;
  logic                  busy;
  logic                  fill_done;
  logic                  pix_dropped;
  logic                  vram_wr_ena;
  logic [ADDR_BITS-1:0]  vram_wr_addr;
  logic [PIXEL_BITS-1:0] vram_wr_data;

  modport master (
    output pix_wr_ena, pix_x, pix_y, pix_data,
    output fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    input  busy, fill_done, pix_dropped,
    input  vram_wr_ena, vram_wr_addr, vram_wr_data
  );

  modport slave (
    input  pix_wr_ena, pix_x, pix_y, pix_data,
    input  fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    output busy, fill_done, pix_dropped,
    output vram_wr_ena, vram_wr_addr, vram_wr_data
  );
endinterface

// File: rtl/tft_vram_fill_engine.sv
// VRAM write-port controller merging single-pixel writes with a clamped rectangle fill.
// Optional checkerboard fill pattern: define TFT_FILL_CHECKER_EN.
module tft_vram_fill_engine #(
  parameter int X_RES      = 480,
  parameter int Y_RES      = 272,
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9,
  parameter int PIXEL_BITS = 9,
  parameter int ADDR_BITS  = 17
) (
  input logic                   cclk,
  input logic                   rstb,
  tft_vram_fill_engine_if.slave io
);
  localparam logic [X_BITS-1:0]    X_MAX     = X_BITS'(X_RES - 1);
  localparam logic [Y_BITS-1:0]    Y_MAX     = Y_BITS'(Y_RES - 1);
  localparam logic [X_BITS-1:0]    X_ONE     = X_BITS'(1);
  localparam logic [Y_BITS-1:0]    Y_ONE     = Y_BITS'(1);
  localparam logic [ADDR_BITS-1:0] LINE_STEP = ADDR_BITS'(X_RES);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;

  state_t                state_r;
  logic [X_BITS-1:0]     xl_r, xh_r, cur_x_r;
  logic [Y_BITS-1:0]     yl_r, yh_r, cur_y_r;
  logic [ADDR_BITS-1:0]  row_base_r;
  logic [PIXEL_BITS-1:0] color_r;
  logic                  busy_r, fill_done_r, pix_dropped_r, wr_ena_r;
  logic [ADDR_BITS-1:0]  wr_addr_r;
  logic [PIXEL_BITS-1:0] wr_data_r;

  logic [X_BITS-1:0]     x_a_s, x_b_s, x_lo_s, x_hi_s, next_x_s;
  logic [Y_BITS-1:0]     y_a_s, y_b_s, y_lo_s, y_hi_s, next_y_s, mul_y_s;
  logic [ADDR_BITS-1:0]  mul_base_s, pix_addr_s, next_base_s, fill_addr_s;
  logic [PIXEL_BITS-1:0] color_s, fill_data_s;
  logic                  pix_ok_s, last_s;

  function automatic logic [X_BITS-1:0] clamp_x(input logic [X_BITS-1:0] v);
    clamp_x = (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [Y_BITS-1:0] clamp_y(input logic [Y_BITS-1:0] v);
    clamp_y = (v > Y_MAX) ? Y_MAX : v;
  endfunction

  // Rectangle normalisation, shared y*X_RES multiplier and next raster position.
  always_comb begin
    x_a_s  = clamp_x(io.fill_x0);
    x_b_s  = clamp_x(io.fill_x1);
    y_a_s  = clamp_y(io.fill_y0);
    y_b_s  = clamp_y(io.fill_y1);
    x_lo_s = (x_a_s < x_b_s) ? x_a_s : x_b_s;
    x_hi_s = (x_a_s < x_b_s) ? x_b_s : x_a_s;
    y_lo_s = (y_a_s < y_b_s) ? y_a_s : y_b_s;
    y_hi_s = (y_a_s < y_b_s) ? y_b_s : y_a_s;
    // The multiplier only ever serves IDLE: first fill row or a pixel write.
    mul_y_s    = io.fill_start ? y_lo_s : io.pix_y;
    mul_base_s = ADDR_BITS'(mul_y_s) * LINE_STEP;
    pix_addr_s = mul_base_s + ADDR_BITS'(io.pix_x);
    pix_ok_s   = (io.pix_x <= X_MAX) && (io.pix_y <= Y_MAX);
    last_s     = (cur_x_r == xh_r) && (cur_y_r == yh_r);
    if (state_r == FILL) begin
      color_s = color_r;
      if (cur_x_r == xh_r) begin
        next_x_s    = xl_r;
        next_y_s    = cur_y_r + Y_ONE;
        next_base_s = row_base_r + LINE_STEP;
      end else begin
        next_x_s    = cur_x_r + X_ONE;
        next_y_s    = cur_y_r;
        next_base_s = row_base_r;
      end
    end else begin
      color_s     = io.fill_color;
      next_x_s    = x_lo_s;
      next_y_s    = y_lo_s;
      next_base_s = mul_base_s;
    end
    fill_addr_s = next_base_s + ADDR_BITS'(next_x_s);
`ifdef TFT_FILL_CHECKER_EN
    fill_data_s = (next_x_s[0] ^ next_y_s[0]) ? ~color_s : color_s;
`else
    fill_data_s = color_s;
`endif
  end

  // Control FSM with registered status and VRAM write port.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_r       <= IDLE;
      xl_r          <= '0;
      xh_r          <= '0;
      yl_r          <= '0;
      yh_r          <= '0;
      cur_x_r       <= '0;
      cur_y_r       <= '0;
      row_base_r    <= '0;
      color_r       <= '0;
      busy_r        <= 1'b0;
      fill_done_r   <= 1'b0;
      pix_dropped_r <= 1'b0;
      wr_ena_r      <= 1'b0;
      wr_addr_r     <= '0;
      wr_data_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          fill_done_r <= 1'b0;
          if (io.fill_start) begin
            state_r       <= FILL;
            xl_r          <= x_lo_s;
            xh_r          <= x_hi_s;
            yl_r          <= y_lo_s;
            yh_r          <= y_hi_s;
            color_r       <= io.fill_color;
            cur_x_r       <= next_x_s;
            cur_y_r       <= next_y_s;
            row_base_r    <= next_base_s;
            busy_r        <= 1'b1;
            pix_dropped_r <= io.pix_wr_ena;
            wr_ena_r      <= 1'b1;
            wr_addr_r     <= fill_addr_s;
            wr_data_r     <= fill_data_s;
          end else if (io.pix_wr_ena && pix_ok_s) begin
            pix_dropped_r <= 1'b0;
            wr_ena_r      <= 1'b1;
            wr_addr_r     <= pix_addr_s;
            wr_data_r     <= io.pix_data;
          end else begin
            pix_dropped_r <= io.pix_wr_ena;
            wr_ena_r      <= 1'b0;
          end
        end
        FILL: begin
          pix_dropped_r <= io.pix_wr_ena;
          if (last_s) begin
            state_r     <= DONE;
            busy_r      <= 1'b0;
            fill_done_r <= 1'b1;
            wr_ena_r    <= 1'b0;
          end else begin
            cur_x_r    <= next_x_s;
            cur_y_r    <= next_y_s;
            row_base_r <= next_base_s;
            wr_ena_r   <= 1'b1;
            wr_addr_r  <= fill_addr_s;
            wr_data_r  <= fill_data_s;
          end
        end
        DONE: begin
          state_r       <= IDLE;
          fill_done_r   <= 1'b0;
          pix_dropped_r <= io.pix_wr_ena;
          wr_ena_r      <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          busy_r        <= 1'b0;
          fill_done_r   <= 1'b0;
          pix_dropped_r <= 1'b0;
          wr_ena_r      <= 1'b0;
        end
      endcase
    end
  end

  assign io.busy         = busy_r;
  assign io.fill_done    = fill_done_r;
  assign io.pix_dropped  = pix_dropped_r;
  assign io.vram_wr_ena  = wr_ena_r;
  assign io.vram_wr_addr = wr_addr_r;
  assign io.vram_wr_data = wr_data_r;
endmodule

// File: tb/tb_tft_vram_fill_engine.sv
// Self-checking bench for tft_vram_fill_engine: raster-order reference model plus write scoreboard.
module tb_tft_vram_fill_engine;
  localparam int XR = 480;
  localparam int YR = 272;

  logic cclk = 1'b0;
  logic rstb = 1'b0;
  int errors = 0;
  int checks = 0;
  int wr_cnt = 0, busy_cnt = 0, done_cnt = 0, drop_cnt = 0;
  int exp_addr_q[$];
  int exp_data_q[$];

  tft_vram_fill_engine_if bus ();
  tft_vram_fill_engine dut (.cclk(cclk), .rstb(rstb), .io(bus));

  always #5 cclk = ~cclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every VRAM write must be the next one the model predicted.
  always @(negedge cclk) begin
    if (bus.vram_wr_ena === 1'b1) begin
      wr_cnt++;
      check("write_expected", exp_addr_q.size() > 0, 1);
      if (exp_addr_q.size() > 0) begin
        check("wr_addr", bus.vram_wr_addr, exp_addr_q.pop_front());
        check("wr_data", bus.vram_wr_data, exp_data_q.pop_front());
      end
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.fill_done === 1'b1) done_cnt++;
    if (bus.pix_dropped === 1'b1) drop_cnt++;
  end

  function automatic int model_color(input int x, input int y, input int color);
`ifdef TFT_FILL_CHECKER_EN
    if (((x ^ y) & 1) != 0) return (~color) & 511;
`endif
    return color;
  endfunction

  // Reference: clamp, order, then enumerate pixels row by row.
  task automatic model_fill(input int x0, input int x1, input int y0, input int y1,
                            input int color, output int area);
    int xa, xb, ya, yb, xl, xh, yl, yh;
    xa = (x0 >= XR) ? XR - 1 : x0;
    xb = (x1 >= XR) ? XR - 1 : x1;
    ya = (y0 >= YR) ? YR - 1 : y0;
    yb = (y1 >= YR) ? YR - 1 : y1;
    xl = (xa < xb) ? xa : xb;
    xh = (xa < xb) ? xb : xa;
    yl = (ya < yb) ? ya : yb;
    yh = (ya < yb) ? yb : ya;
    area = (xh - xl + 1) * (yh - yl + 1);
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        exp_addr_q.push_back(y * XR + x);
        exp_data_q.push_back(model_color(x, y, color));
      end
  endtask

  task automatic run_fill(input int x0, input int x1, input int y0, input int y1,
                          input int color, input bit collide, input bit inj, input bit hold);
    int area, inj_k;
    model_fill(x0, x1, y0, y1, color, area);
    inj_k = $urandom_range(0, area - 1);
    @(posedge cclk); #1;
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; drop_cnt = 0;
    bus.fill_x0 = 10'(x0); bus.fill_x1 = 10'(x1);
    bus.fill_y0 = 9'(y0);  bus.fill_y1 = 9'(y1);
    bus.fill_color = 9'(color);
    bus.fill_start = 1'b1;
    bus.pix_x = 10'd3; bus.pix_y = 9'd2; bus.pix_data = 9'h155;
    bus.pix_wr_ena = collide;
    for (int i = 0; i < area + 20; i++) begin
      @(posedge cclk); #1;
      bus.fill_start = hold && (i == 0);
      bus.pix_wr_ena = inj && (i == inj_k);
      if (done_cnt != 0) break;
    end
    bus.fill_start = 1'b0;
    bus.pix_wr_ena = 1'b0;
    check("fill_done_pulses", done_cnt, 1);
    check("fill_writes", wr_cnt, area);
    check("busy_cycles", busy_cnt, area);
    check("fill_left_over", exp_addr_q.size(), 0);
    check("fill_drops", drop_cnt, int'(collide) + int'(inj));
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic do_pixel(input int x, input int y, input int d);
    bit ok;
    ok = (x < XR) && (y < YR);
    if (ok) begin
      exp_addr_q.push_back(y * XR + x);
      exp_data_q.push_back(d);
    end
    @(posedge cclk); #1;
    bus.pix_x = 10'(x); bus.pix_y = 9'(y); bus.pix_data = 9'(d);
    bus.pix_wr_ena = 1'b1;
    @(posedge cclk); #1;
    bus.pix_wr_ena = 1'b0;
    @(negedge cclk);
    check("pix_ena", bus.vram_wr_ena, ok);
    check("pix_drop", bus.pix_dropped, !ok);
    if (ok) check("pix_addr", bus.vram_wr_addr, y * XR + x);
    @(negedge cclk);
    check("pix_single", bus.vram_wr_ena, 0);
  endtask

  initial begin
    int x0, x1, y0, y1, c;
    bus.pix_wr_ena = 1'b0; bus.pix_x = '0; bus.pix_y = '0; bus.pix_data = '0;
    bus.fill_start = 1'b0; bus.fill_x0 = '0; bus.fill_x1 = '0;
    bus.fill_y0 = '0; bus.fill_y1 = '0; bus.fill_color = '0;
    #12;
    check("rst_ena", bus.vram_wr_ena, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.fill_done, 0);
    check("rst_drop", bus.pix_dropped, 0);
    check("rst_addr", bus.vram_wr_addr, 0);
    check("rst_data", bus.vram_wr_data, 0);
    @(posedge cclk); #1;
    rstb = 1'b1;

    // Reset mid-way through a full clear.
    for (int i = 0; i < 1000; i++) begin
      exp_addr_q.push_back(i);
      exp_data_q.push_back(9'h0AA);
    end
    @(posedge cclk); #1;
    wr_cnt = 0; done_cnt = 0;
    bus.fill_x0 = 10'd0; bus.fill_x1 = 10'(XR - 1);
    bus.fill_y0 = 9'd0;  bus.fill_y1 = 9'(YR - 1);
    bus.fill_color = 9'h0AA; bus.fill_start = 1'b1;
    @(posedge cclk); #1;
    bus.fill_start = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge cclk); #1;
      if (wr_cnt >= 1000) break;
    end
    check("rst_mid_writes", wr_cnt, 1000);
    rstb = 1'b0;
    #1;
    check("rst_mid_ena", bus.vram_wr_ena, 0);
    check("rst_mid_busy", bus.busy, 0);
    repeat (3) @(posedge cclk);
    #1;
    rstb = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_no_more", wr_cnt, 1000);
    check("rst_mid_busy_after", bus.busy, 0);

    // Directed fills: last 64 full lines, reversed/clamped, single pixel, 2x2.
    run_fill(0, XR - 1, 208, YR - 1, 9'h000, 1'b0, 1'b0, 1'b0);
    run_fill(10, 7, 300, 270, 9'h1A5, 1'b0, 1'b0, 1'b0);
    run_fill(5, 5, 9, 9, 9'h033, 1'b0, 1'b0, 1'b0);
    run_fill(0, 1, 0, 1, 9'h0F0, 1'b0, 1'b0, 1'b0);
    run_fill(100, 103, 40, 41, 9'h111, 1'b1, 1'b1, 1'b1);

    // Directed pixels including edges and out-of-range.
    do_pixel(3, 2, 9'h1FF);
    do_pixel(480, 0, 9'h001);
    do_pixel(0, 272, 9'h002);
    do_pixel(XR - 1, YR - 1, 9'h0C3);

    // Randomized rectangles and pixels.
    for (int r = 0; r < 16; r++) begin
      x0 = $urandom_range(0, 1023);
      x1 = x0 + $urandom_range(0, 20) - 10;
      if (x1 < 0) x1 = 0;
      if (x1 > 1023) x1 = 1023;
      y0 = $urandom_range(0, 511);
      y1 = y0 + $urandom_range(0, 20) - 10;
      if (y1 < 0) y1 = 0;
      if (y1 > 511) y1 = 511;
      c = $urandom_range(0, 511);
      run_fill(x0, x1, y0, y1, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end
    for (int p = 0; p < 24; p++) begin
      x0 = $urandom_range(0, 520);
      y0 = $urandom_range(0, 300);
      c = $urandom_range(0, 511);
      do_pixel(x0, y0, c);
    end
    check("final_queue_empty", exp_addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
